// File: rtl/result_router_pkg.sv
// Shared unit-tag encoding for the result arbiter and result router.
package result_router_pkg;

    localparam int NUM_UNITS = 3;

    localparam logic [2:0] UNIT_A = 3'b001;
    localparam logic [2:0] UNIT_B = 3'b010;
    localparam logic [2:0] UNIT_C = 3'b100;

    function automatic logic is_onehot3(input logic [2:0] tag);
        return (tag == UNIT_A) || (tag == UNIT_B) || (tag == UNIT_C);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Per-unit result FIFO: registered head, no fall-through, no pop-through.
module result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally at their width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_router.sv
// Steers the arbitrated result stream to per-unit FIFOs by one-hot tag.
// Optional invalid-tag counter enabled with RESULT_ROUTER_ERR_CNT_EN.
module result_router
    import result_router_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result,
    input  logic             result_valid,
    input  logic [2:0]       result_unit,
    output logic             result_ack,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic             out_a_valid,
    output logic             out_b_valid,
    output logic             out_c_valid,
    input  logic             out_a_ready,
    input  logic             out_b_ready,
    input  logic             out_c_ready
`ifdef RESULT_ROUTER_ERR_CNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    logic                 tag_valid;
    logic [NUM_UNITS-1:0] sel;
    logic [NUM_UNITS-1:0] full;
    logic [NUM_UNITS-1:0] empty;
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] pop;
    logic [NUM_UNITS-1:0] ready;
    logic [WIDTH-1:0]     head [NUM_UNITS];

    assign tag_valid = is_onehot3(result_unit);
    assign sel       = tag_valid ? result_unit : '0;

    // An invalid tag leaves sel at zero, so the word is always accepted and dropped.
    assign result_ack = ~rst & result_valid & ~|(full & sel);
    assign push       = sel & {NUM_UNITS{result_ack}};
    assign ready      = {out_c_ready, out_b_ready, out_a_ready};
    assign pop        = ~empty & ready;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        result_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[u]),
            .push_data (result),
            .pop       (pop[u]),
            .full      (full[u]),
            .empty     (empty[u]),
            .head      (head[u])
        );
    end

    assign out_a       = head[0];
    assign out_b       = head[1];
    assign out_c       = head[2];
    assign out_a_valid = ~empty[0];
    assign out_b_valid = ~empty[1];
    assign out_c_valid = ~empty[2];

`ifdef RESULT_ROUTER_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (result_ack && !tag_valid && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
